// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core.
// Produces the EX-stage forwarding selects, load-use and multi-cycle scoreboard stalls,
// and the flush pulse that follows a control redirect.
// It also keeps a saturating count of the cycles in which stall_fd was asserted.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] de_adr1,
    input  logic [ADDR_W-1:0] de_adr2,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic              de_is_mc,
    input  logic [ADDR_W-1:0] ex_adr1,
    input  logic [ADDR_W-1:0] ex_adr2,
    input  logic              ex_rs1_used,
    input  logic              ex_rs2_used,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_regWrite,
    input  logic              ex_is_load,
    input  logic              ex_issue_mc,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              mem_regWrite,
    input  logic              wb_regWrite,
    input  logic              mc_done,
    input  logic [ADDR_W-1:0] mc_rd,
    input  logic [1:0]        pc_source,
    output logic [1:0]        fsel1,
    output logic [1:0]        fsel2,
    output logic              stall_fd,
    output logic              bubble_ex,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int FC_W = 3;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

    logic [1:0] fsel1_raw, fsel2_raw;
    logic       lu, sb_haz, flush_raw, stall_raw;

    // Forwarding selects for both EX operands; MEM has priority over WB and x0 is never forwarded.
    always_comb begin
        fsel1_raw = 2'b00;
        fsel2_raw = 2'b00;
        if (ex_rs1_used && ex_adr1 != '0) begin
            if (mem_regWrite && mem_rd == ex_adr1)     fsel1_raw = 2'b01;
            else if (wb_regWrite && wb_rd == ex_adr1)  fsel1_raw = 2'b10;
        end
        if (ex_rs2_used && ex_adr2 != '0) begin
            if (mem_regWrite && mem_rd == ex_adr2)     fsel2_raw = 2'b01;
            else if (wb_regWrite && wb_rd == ex_adr2)  fsel2_raw = 2'b10;
        end
    end

    // Hazard detection and output combination; a flush suppresses any stall.
    always_comb begin
        lu = ex_is_load && ex_regWrite && (ex_rd != '0) &&
             ((de_rs1_used && de_adr1 == ex_rd) || (de_rs2_used && de_adr2 == ex_rd));
        // Only the registered pending bits are examined, so a dependent instruction
        // is released one cycle after mc_done (no same-cycle bypass).
        sb_haz = (de_rs1_used && pending_q[de_adr1]) ||
                 (de_rs2_used && pending_q[de_adr2]) ||
                 (de_is_mc && (|pending_q));
        flush_raw = (pc_source != 2'b00) || (flush_cnt_q != '0);
        stall_raw = (lu || sb_haz) && !flush_raw;
    end

    // Outputs are held at zero for as long as reset is asserted.
    always_comb begin
        fsel1        = rst_n ? fsel1_raw : 2'b00;
        fsel2        = rst_n ? fsel2_raw : 2'b00;
        stall_fd     = rst_n & stall_raw;
        bubble_ex    = rst_n & stall_raw;
        flush        = rst_n & flush_raw;
        stall_cycles = stall_cycles_q;
    end

    // Next-state logic for the scoreboard, the flush countdown and the stall counter.
    always_comb begin
        pending_d = pending_q;
        if (mc_done)
            pending_d[mc_rd] = 1'b0;
        // The set is applied after the clear, so a set and a clear of the same register in one cycle leave it pending.
        if (ex_issue_mc && ex_rd != '0)
            pending_d[ex_rd] = 1'b1;
        pending_d[0] = 1'b0;

        flush_cnt_d = flush_cnt_q;
        if (pc_source != 2'b00)
            flush_cnt_d = FC_W'(FLUSH_DEPTH - 1);
        else if (flush_cnt_q != '0)
            flush_cnt_d = flush_cnt_q - FC_W'(1);

        stall_cycles_d = stall_cycles_q;
        if (stall_raw && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    // State registers; reset discards any in-flight redirect or multi-cycle op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= '0;
            flush_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            pending_q      <= pending_d;
            flush_cnt_q    <= flush_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (FLUSH_DEPTH=3, CNT_W=4 so saturation is reachable).
module tb_hazard_scoreboard;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] de_adr1, de_adr2, ex_adr1, ex_adr2, ex_rd, mem_rd, wb_rd, mc_rd;
    logic de_rs1_used, de_rs2_used, de_is_mc, ex_rs1_used, ex_rs2_used;
    logic ex_regWrite, ex_is_load, ex_issue_mc, mem_regWrite, wb_regWrite, mc_done;
    logic [1:0] pc_source, fsel1, fsel2;
    logic stall_fd, bubble_ex, flush;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(32), .FLUSH_DEPTH(3), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .de_adr1(de_adr1), .de_adr2(de_adr2), .de_rs1_used(de_rs1_used),
        .de_rs2_used(de_rs2_used), .de_is_mc(de_is_mc),
        .ex_adr1(ex_adr1), .ex_adr2(ex_adr2), .ex_rs1_used(ex_rs1_used),
        .ex_rs2_used(ex_rs2_used), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
        .ex_is_load(ex_is_load), .ex_issue_mc(ex_issue_mc),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regWrite(mem_regWrite),
        .wb_regWrite(wb_regWrite), .mc_done(mc_done), .mc_rd(mc_rd),
        .pc_source(pc_source), .fsel1(fsel1), .fsel2(fsel2),
        .stall_fd(stall_fd), .bubble_ex(bubble_ex), .flush(flush),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic [4:0] de_adr1, de_adr2;
        logic       de_u1, de_u2;
        logic [4:0] ex_adr1, ex_adr2;
        logic       ex_u1, ex_u2;
        logic [4:0] ex_rd;
        logic       ex_rw, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [1:0] f1, f2;
        logic       st;
    } vec_t;

    function automatic vec_t mk(int d1, int d2, int du1, int du2, int e1, int e2, int eu1, int eu2,
                                int rd, int rw, int ld, int mr, int mw, int wr, int ww,
                                int f1, int f2, int st);
        vec_t v;
        v.de_adr1 = 5'(d1);  v.de_adr2 = 5'(d2);  v.de_u1 = 1'(du1); v.de_u2 = 1'(du2);
        v.ex_adr1 = 5'(e1);  v.ex_adr2 = 5'(e2);  v.ex_u1 = 1'(eu1); v.ex_u2 = 1'(eu2);
        v.ex_rd   = 5'(rd);  v.ex_rw   = 1'(rw);  v.ex_ld = 1'(ld);
        v.mem_rd  = 5'(mr);  v.mem_rw  = 1'(mw);  v.wb_rd = 5'(wr); v.wb_rw = 1'(ww);
        v.f1 = 2'(f1); v.f2 = 2'(f2); v.st = 1'(st);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        de_adr1 = 0; de_adr2 = 0; de_rs1_used = 0; de_rs2_used = 0; de_is_mc = 0;
        ex_adr1 = 0; ex_adr2 = 0; ex_rs1_used = 0; ex_rs2_used = 0;
        ex_rd = 0; ex_regWrite = 0; ex_is_load = 0; ex_issue_mc = 0;
        mem_rd = 0; wb_rd = 0; mem_regWrite = 0; wb_regWrite = 0;
        mc_done = 0; mc_rd = 0; pc_source = 2'b00;
    endtask

    // Check one cycle at the falling edge, update the counter model, then advance past the rising edge.
    task automatic cyc(input string nm, input int f1, input int f2, input int st, input int fl);
        @(negedge clk);
        chk({nm, ".fsel1"}, int'(fsel1), f1);
        chk({nm, ".fsel2"}, int'(fsel2), f2);
        chk({nm, ".stall_fd"}, int'(stall_fd), st);
        chk({nm, ".bubble_ex"}, int'(bubble_ex), st);
        chk({nm, ".flush"}, int'(flush), fl);
        chk({nm, ".stall_cycles"}, int'(stall_cycles), exp_cnt);
        if (st != 0 && exp_cnt < 15) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".fsel1"}, int'(fsel1), 0);
        chk({nm, ".fsel2"}, int'(fsel2), 0);
        chk({nm, ".stall_fd"}, int'(stall_fd), 0);
        chk({nm, ".bubble_ex"}, int'(bubble_ex), 0);
        chk({nm, ".flush"}, int'(flush), 0);
        chk({nm, ".stall_cycles"}, int'(stall_cycles), 0);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0);
        vecs[1]  = mk(0,0,0,0, 3,0,1,0, 0,0,0, 3,1, 3,1, 1,0,0);
        vecs[2]  = mk(0,0,0,0, 0,0,1,0, 0,0,0, 0,1, 0,1, 0,0,0);
        vecs[3]  = mk(0,0,0,0, 0,7,0,1, 0,0,0, 0,0, 7,1, 0,2,0);
        vecs[4]  = mk(0,0,0,0, 4,0,0,0, 0,0,0, 4,1, 0,0, 0,0,0);
        vecs[5]  = mk(0,0,0,0, 4,4,1,1, 0,0,0, 4,0, 4,1, 2,2,0);
        vecs[6]  = mk(5,7,1,1, 0,0,0,0, 5,1,1, 0,0, 0,0, 0,0,1);
        vecs[7]  = mk(5,7,0,1, 0,0,0,0, 5,1,1, 0,0, 0,0, 0,0,0);
        vecs[8]  = mk(0,0,1,1, 0,0,0,0, 0,1,1, 0,0, 0,0, 0,0,0);
        vecs[9]  = mk(1,5,1,1, 0,0,0,0, 5,1,1, 0,0, 0,0, 0,0,1);
        vecs[10] = mk(1,5,1,1, 0,0,0,0, 5,0,1, 0,0, 0,0, 0,0,0);
        vecs[11] = mk(5,0,1,0, 0,0,0,0, 5,1,0, 0,0, 0,0, 0,0,0);
        vecs[12] = mk(0,0,0,0, 2,6,1,1, 0,0,0, 2,1, 6,1, 1,2,0);
        vecs[13] = mk(0,0,0,0, 8,8,1,1, 0,0,0, 8,1, 8,1, 1,1,0);

        // Reset: outputs must be zero even with forwarding inputs active.
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        ex_adr1 = 3; ex_rs1_used = 1; mem_rd = 3; mem_regWrite = 1;
        #1;
        chk_all_zero("reset");
        idle();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Combinational forwarding / load-use table.
        for (int i = 0; i < 14; i++) begin
            idle();
            de_adr1 = vecs[i].de_adr1; de_adr2 = vecs[i].de_adr2;
            de_rs1_used = vecs[i].de_u1; de_rs2_used = vecs[i].de_u2;
            ex_adr1 = vecs[i].ex_adr1; ex_adr2 = vecs[i].ex_adr2;
            ex_rs1_used = vecs[i].ex_u1; ex_rs2_used = vecs[i].ex_u2;
            ex_rd = vecs[i].ex_rd; ex_regWrite = vecs[i].ex_rw; ex_is_load = vecs[i].ex_ld;
            mem_rd = vecs[i].mem_rd; mem_regWrite = vecs[i].mem_rw;
            wb_rd = vecs[i].wb_rd; wb_regWrite = vecs[i].wb_rw;
            cyc($sformatf("vec%0d", i), int'(vecs[i].f1), int'(vecs[i].f2), int'(vecs[i].st), 0);
        end

        // Load x5 in EX, add x6,x5,x7 in DE: a single-cycle stall, then MEM and WB forwarding.
        idle();
        ex_rd = 5; ex_regWrite = 1; ex_is_load = 1;
        de_adr1 = 5; de_rs1_used = 1; de_adr2 = 7; de_rs2_used = 1;
        cyc("lu_stall", 0, 0, 1, 0);
        idle();
        ex_adr1 = 5; ex_rs1_used = 1; ex_adr2 = 7; ex_rs2_used = 1;
        ex_rd = 6; ex_regWrite = 1; mem_rd = 5; mem_regWrite = 1;
        cyc("lu_memfwd", 1, 0, 0, 0);
        idle();
        ex_adr2 = 5; ex_rs2_used = 1; mem_rd = 6; mem_regWrite = 1; wb_rd = 5; wb_regWrite = 1;
        cyc("lu_wbfwd", 0, 2, 0, 0);

        // Multi-cycle op to x9: a reader of x9 stalls until the cycle after mc_done.
        idle();
        ex_issue_mc = 1; ex_rd = 9;
        cyc("mc_issue", 0, 0, 0, 0);
        idle();
        de_adr1 = 9; de_rs1_used = 1;
        for (int i = 0; i < 3; i++) cyc($sformatf("mc_hold%0d", i), 0, 0, 1, 0);
        mc_done = 1; mc_rd = 9;
        cyc("mc_done_cycle", 0, 0, 1, 0);
        mc_done = 0;
        cyc("mc_released", 0, 0, 0, 0);

        // Set and clear of x9 in the same cycle leave x9 pending.
        idle();
        ex_issue_mc = 1; ex_rd = 9;
        cyc("mc_set", 0, 0, 0, 0);
        mc_done = 1; mc_rd = 9;
        cyc("mc_setclr", 0, 0, 0, 0);
        idle();
        de_adr2 = 9; de_rs2_used = 1;
        cyc("mc_still_pend", 0, 0, 1, 0);
        mc_done = 1; mc_rd = 9;
        cyc("mc_clr2", 0, 0, 1, 0);
        idle();
        de_adr2 = 9; de_rs2_used = 1;
        cyc("mc_clr2_rel", 0, 0, 0, 0);

        // de_is_mc waits on any pending register; an issue to x0 never becomes pending.
        idle();
        ex_issue_mc = 1; ex_rd = 10;
        cyc("mc_issue10", 0, 0, 0, 0);
        idle();
        de_is_mc = 1;
        cyc("mc_any_pend", 0, 0, 1, 0);
        de_is_mc = 0; mc_done = 1; mc_rd = 10;
        cyc("mc_clr10", 0, 0, 0, 0);
        idle();
        ex_issue_mc = 1; ex_rd = 0;
        cyc("mc_issue_x0", 0, 0, 0, 0);
        idle();
        de_is_mc = 1; de_adr1 = 0; de_rs1_used = 1;
        cyc("mc_x0_nopend", 0, 0, 0, 0);

        // A single redirect holds flush for three cycles.
        idle();
        pc_source = 2'b01;
        cyc("fl_c1", 0, 0, 0, 1);
        pc_source = 2'b00;
        cyc("fl_c2", 0, 0, 0, 1);
        cyc("fl_c3", 0, 0, 0, 1);
        cyc("fl_c4", 0, 0, 0, 0);

        // A second redirect in cycle 2 reloads the countdown, so flush lasts through cycle 4.
        pc_source = 2'b10;
        cyc("rf_c1", 0, 0, 0, 1);
        pc_source = 2'b11;
        cyc("rf_c2", 0, 0, 0, 1);
        pc_source = 2'b00;
        cyc("rf_c3", 0, 0, 0, 1);
        cyc("rf_c4", 0, 0, 0, 1);
        cyc("rf_c5", 0, 0, 0, 0);

        // A load-use hazard that coincides with a flush produces no stall.
        ex_rd = 5; ex_regWrite = 1; ex_is_load = 1; de_adr1 = 5; de_rs1_used = 1;
        pc_source = 2'b01;
        cyc("fl_lu1", 0, 0, 0, 1);
        pc_source = 2'b00;
        cyc("fl_lu2", 0, 0, 0, 1);
        cyc("fl_lu3", 0, 0, 0, 1);
        cyc("fl_lu4", 0, 0, 1, 0);

        // Reset in the middle of a flush while x4 is pending.
        idle();
        ex_issue_mc = 1; ex_rd = 4;
        cyc("rst_issue4", 0, 0, 0, 0);
        idle();
        pc_source = 2'b01;
        cyc("rst_redirect", 0, 0, 0, 1);
        idle();
        ex_adr1 = 3; ex_rs1_used = 1; mem_rd = 3; mem_regWrite = 1;
        de_adr1 = 4; de_rs1_used = 1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        #2;
        idle();
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        de_adr1 = 4; de_rs1_used = 1;
        cyc("post_rst_x4", 0, 0, 0, 0);
        de_is_mc = 1;
        cyc("post_rst_mc", 0, 0, 0, 0);

        // Hold a load-use stall long enough for the counter to saturate.
        idle();
        ex_rd = 5; ex_regWrite = 1; ex_is_load = 1; de_adr1 = 5; de_rs1_used = 1;
        for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), 0, 0, 1, 0);
        idle();
        cyc("sat_end", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
